// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle for the multicycle RV32 subset controller.
// master = controller side, slave = datapath/memory side.
interface multicycle_control_if;
  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned INSTRET_W = 32;

  logic [OPCODE_W-1:0]  opcode;
  logic                 zero;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 ir_write;
  logic                 mem_read;
  logic                 mem_write;
  logic                 reg_write;
  logic                 mem_to_reg;
  logic                 i_or_d;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           aluop;
  logic                 illegal;
  logic [INSTRET_W-1:0] instret;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, i_or_d,
           alu_src_a, alu_src_b, aluop, illegal, instret
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, i_or_d,
           alu_src_a, alu_src_b, aluop, illegal, instret
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle controller: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT sequencing,
// datapath enables, sticky illegal flag and retired-instruction counter.
module multicycle_control #(
  // Value instret takes on reset; nonzero only for counter-wrap bring-up.
  parameter logic [31:0] INSTRET_RST = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned STATE_W  = 3;

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

  logic [STATE_W-1:0]  r_state;
  logic [STATE_W-1:0]  w_next;
  logic [OPCODE_W-1:0] r_op;
  logic                r_illegal;
  logic [31:0]         r_instret;
  logic                w_legal;
  logic                w_retire;

  // Decode is done on the live opcode; later states use the latched copy.
  assign w_legal = (bus.opcode == OP_R)     || (bus.opcode == OP_I) ||
                   (bus.opcode == OP_LOAD)  || (bus.opcode == OP_STORE) ||
                   (bus.opcode == OP_BRANCH);

  // Next-state, retirement and datapath control; reset forces all outputs low.
  always_comb begin
    w_next         = r_state;
    w_retire       = 1'b0;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.aluop      = 2'b00;
    case (r_state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          w_next       = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b10;
        w_next        = w_legal ? S_EXECUTE : S_HALT;
      end
      S_EXECUTE: begin
        bus.alu_src_a = 1'b1;
        case (r_op)
          OP_R: begin
            bus.aluop = 2'b10;
            w_next    = S_WRITEBACK;
          end
          OP_I: begin
            bus.alu_src_b = 2'b10;
            bus.aluop     = 2'b10;
            w_next        = S_WRITEBACK;
          end
          OP_LOAD, OP_STORE: begin
            bus.alu_src_b = 2'b10;
            w_next        = S_MEMORY;
          end
          OP_BRANCH: begin
            bus.aluop    = 2'b01;
            bus.pc_write = bus.zero;
            w_next       = S_FETCH;
            w_retire     = 1'b1;
          end
          default: w_next = S_HALT;
        endcase
      end
      S_MEMORY: begin
        bus.i_or_d    = 1'b1;
        bus.mem_read  = (r_op == OP_LOAD);
        bus.mem_write = (r_op == OP_STORE);
        if (bus.mem_ready) begin
          w_next   = (r_op == OP_LOAD) ? S_WRITEBACK : S_FETCH;
          w_retire = (r_op == OP_STORE);
        end
      end
      S_WRITEBACK: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = (r_op == OP_LOAD);
        w_next         = S_FETCH;
        w_retire       = 1'b1;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
    if (reset) begin
      bus.pc_write   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.i_or_d     = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.aluop      = 2'b00;
    end
  end

  // State register, latched opcode, sticky illegal flag and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_op      <= '0;
      r_illegal <= 1'b0;
      r_instret <= INSTRET_RST;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op <= bus.opcode;
        if (!w_legal) r_illegal <= 1'b1;
      end
      if (w_retire) r_instret <= r_instret + 32'd1;
    end
  end

  assign bus.illegal = r_illegal;
  assign bus.instret = r_instret;
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have the port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 The block SHALL have the port: reset  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have the port: opcode  input  7  instruction[6:0] from instruction register; valid from DECODE onward.
REQ-004 The block SHALL have the port: zero  input  1  ALU zero flag; sampled in EXECUTE for branches.
REQ-005 The block SHALL have the port: mem_ready  input  1  memory handshake; access completes in the cycle it is high.
REQ-006 The block SHALL have the ports: pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, i_or_d  output  1 each  datapath enables and mux selects.
REQ-007 The block SHALL have the ports: alu_src_a  output  1 (0=PC, 1=rs1); alu_src_b  output  2 (00=rs2, 01=const 4, 10=imm).
REQ-008 The block SHALL have the port: aluop  output  2  ALU-decoder class (00 add, 01 sub, 10 funct-decoded).
REQ-009 The block SHALL have the ports: illegal  output  1  sticky illegal-opcode flag; instret  output  32  retired-instruction count.

Function
REQ-010 The block SHALL implement states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT in a single state register.
REQ-011 The block SHALL decode opcodes: R=0110011, I-ALU=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011 (beq); any other opcode is illegal.
REQ-012 In FETCH the block SHALL assert mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, aluop=00, and stay in FETCH while mem_ready=0.
REQ-013 In FETCH with mem_ready=1 the block SHALL assert ir_write=1 and pc_write=1 for exactly that cycle and go to DECODE next.
REQ-014 In DECODE the block SHALL drive alu_src_a=0, alu_src_b=10, aluop=00 (branch target), latch opcode into an internal op register, and go to EXECUTE for a legal opcode or HALT otherwise.
REQ-015 In EXECUTE the block SHALL drive alu_src_a=1 and, by latched op: R -> alu_src_b=00, aluop=10; I-ALU -> 10, 10; LOAD/STORE -> 10, 00; BRANCH -> 00, 01.
REQ-016 From EXECUTE the block SHALL go to WRITEBACK (R, I-ALU), MEMORY (LOAD, STORE) or FETCH (BRANCH).
REQ-017 In EXECUTE for BRANCH the block SHALL assert pc_write=1 iff zero=1 in that cycle.
REQ-018 In MEMORY the block SHALL drive i_or_d=1 with mem_read=1 (LOAD) or mem_write=1 (STORE), hold until mem_ready=1, then go to WRITEBACK (LOAD) or FETCH (STORE).
REQ-019 In WRITEBACK the block SHALL assert reg_write=1 for one cycle, mem_to_reg=1 for LOAD else 0, then go to FETCH.
REQ-020 The block SHALL increment instret by 1 (mod 2^32, wraps 0xFFFFFFFF -> 0) on each retirement: leaving WRITEBACK, leaving MEMORY for STORE, or leaving EXECUTE for BRANCH.
REQ-021 In HALT the block SHALL hold illegal=1, drive all enables 0, and remain in HALT until reset.
REQ-022 Every output not listed for the current state SHALL be 0; no two of pc_write/ir_write/reg_write/mem_write SHALL fire outside the cases above.
REQ-023 Cycle counts with mem_ready always 1 SHALL be: R/I-ALU 4, LOAD 5, STORE 4, BRANCH 3 cycles.

Reset
REQ-024 With reset=1 at a rising edge, the block SHALL enter FETCH, clear op register, illegal=0, instret=0, regardless of current state including HALT or a stalled MEMORY access.
REQ-025 While reset=1 the block SHALL drive all write/read enables to 0, overriding the FETCH decode.
REQ-026 On the first edge with reset=0, the block SHALL start a FETCH with no extra idle cycle.

Verification
REQ-027 The bench SHALL check: R-type add, mem_ready=1 -> states F,D,E,W; reg_write=1 only in 4th cycle; instret 0->1.
REQ-028 The bench SHALL check: LOAD with mem_ready low for 3 MEMORY cycles -> mem_read,i_or_d held 4 cycles; WRITEBACK mem_to_reg=1; total 8 cycles.
REQ-029 The bench SHALL check: BRANCH with zero=1 then zero=0 -> pc_write in EXECUTE only for first; aluop=01 both; 3 cycles each.
REQ-030 The bench SHALL check: opcode 1111111 -> HALT after DECODE, illegal=1, no enables for 10 cycles; reset -> illegal=0, FETCH.
REQ-031 The bench SHALL check: reset asserted mid-MEMORY STORE with mem_ready=0 -> next cycle FETCH, mem_write=0, instret=0.
REQ-032 The bench SHALL check: instret forced near 0xFFFFFFFF via 1 preloaded retirement sequence -> wraps to 0x00000000 without affecting state flow.
